// File: rtl/med_pkg.sv
// Shared types and constants for the median sequencing controller.
package med_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SORT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int NB_DEF    = 9;
    localparam int NPASS_DEF = 5;

    // Cycles from the first DSI sample to the DSO pulse for an nb-sample window.
    function automatic int lat(input int nb);
        return nb + ((nb + 1) / 2 - 1) * nb + (nb - (nb + 1) / 2);
    endfunction

endpackage

// File: rtl/med_ctrl.sv
// Load/sort sequencer for the 9-tap median datapath (DSI_MED/BYP control, DSO strobe).
// Optional ERR output for protocol violations: define MED_CTRL_PROTO_CHECK_EN.
module med_ctrl
    import med_pkg::*;
#(
    parameter int NB = NB_DEF
)(
    input  logic CLK,
    input  logic nRST,
    input  logic DSI,
    output logic DSI_MED,
    output logic BYP,
    output logic DSO,
    output logic BUSY
`ifdef MED_CTRL_PROTO_CHECK_EN
    ,
    output logic ERR
`endif
);

    localparam int NPASS = (NB + 1) / 2;
    localparam int PW    = (NPASS > 1) ? $clog2(NPASS) : 1;
    localparam int CW    = $clog2(NB);

    localparam logic [CW-1:0] C_LAST  = CW'(NB - 1);
    localparam logic [CW-1:0] C_FINAL = CW'(NB - NPASS - 1);
    localparam logic [PW-1:0] P_LAST  = PW'(NPASS - 1);

    state_t          r_state;
    logic [CW-1:0]   r_c;
    logic [PW-1:0]   r_p;
    logic            r_dso;
    logic            r_busy;

    state_t          w_state_nxt;
    logic [CW-1:0]   w_c_nxt;
    logic [PW-1:0]   w_p_nxt;
    logic [CW-1:0]   w_cmp_len;

`ifdef MED_CTRL_PROTO_CHECK_EN
    logic            r_err;
    logic            w_err_evt;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_c_nxt     = r_c;
        w_p_nxt     = r_p;
        w_cmp_len   = C_LAST - CW'(r_p);
        DSI_MED     = 1'b0;
        BYP         = 1'b1;
`ifdef MED_CTRL_PROTO_CHECK_EN
        w_err_evt   = 1'b0;
`endif
        case (r_state)
            IDLE, DONE: begin
                DSI_MED = DSI;
                w_p_nxt = '0;
                if (DSI) begin
                    w_state_nxt = LOAD;
                    w_c_nxt     = CW'(1);
                end else begin
                    w_state_nxt = IDLE;
                    w_c_nxt     = '0;
                end
            end
            LOAD: begin
                DSI_MED = DSI;
                if (DSI) begin
                    if (r_c == C_LAST) begin
                        w_state_nxt = SORT;
                        w_c_nxt     = '0;
                        w_p_nxt     = '0;
                    end else begin
                        w_c_nxt = r_c + CW'(1);
                    end
                end else begin
                    // Short burst: the partial window in the datapath is abandoned.
                    w_state_nxt = IDLE;
                    w_c_nxt     = '0;
                    w_p_nxt     = '0;
`ifdef MED_CTRL_PROTO_CHECK_EN
                    w_err_evt   = 1'b1;
`endif
                end
            end
            SORT: begin
                BYP = (r_c < w_cmp_len) ? 1'b0 : 1'b1;
`ifdef MED_CTRL_PROTO_CHECK_EN
                w_err_evt = DSI;
`endif
                if (r_p == P_LAST) begin
                    // Final pass stops once the running max is the median; no bypass tail.
                    if (r_c == C_FINAL) begin
                        w_state_nxt = DONE;
                        w_c_nxt     = '0;
                        w_p_nxt     = '0;
                    end else begin
                        w_c_nxt = r_c + CW'(1);
                    end
                end else if (r_c == C_LAST) begin
                    w_c_nxt = '0;
                    w_p_nxt = r_p + PW'(1);
                end else begin
                    w_c_nxt = r_c + CW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_c_nxt     = '0;
                w_p_nxt     = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_c     <= '0;
            r_p     <= '0;
            r_dso   <= 1'b0;
            r_busy  <= 1'b0;
`ifdef MED_CTRL_PROTO_CHECK_EN
            r_err   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_c     <= w_c_nxt;
            r_p     <= w_p_nxt;
            r_dso   <= (w_state_nxt == DONE);
            r_busy  <= (w_state_nxt == LOAD) || (w_state_nxt == SORT);
`ifdef MED_CTRL_PROTO_CHECK_EN
            r_err   <= r_err | w_err_evt;
`endif
        end
    end

    assign DSO  = r_dso;
    assign BUSY = r_busy;
`ifdef MED_CTRL_PROTO_CHECK_EN
    assign ERR  = r_err;
`endif

endmodule

// File: tb/tb_med_ctrl.sv
// Bench for med_ctrl with a behavioural min/max ring datapath; NB=9 and NB=5 instances.
// Build with MED_CTRL_PROTO_CHECK_EN to also exercise the ERR output.
module tb_med_ctrl;

    logic CLK = 1'b0;
    logic nRST;
    logic DSI9, DSI_MED9, BYP9, DSO9, BUSY9;
    logic DSI5, DSI_MED5, BYP5, DSO5, BUSY5;
`ifdef MED_CTRL_PROTO_CHECK_EN
    logic err9, err5;
`endif

    int di9, di5;
    int dp9 [9];
    int dp5 [5];

    int n_tests = 0;
    int n_fail  = 0;

    bit   sch_dsi  [120];
    int   sch_di   [120];
    logic obs_byp  [120];
    logic obs_dso  [120];
    logic obs_busy [120];
    logic obs_dsim [120];
    int   obs_do   [120];
    logic exp_byp  [120];
    logic exp_busy [120];
    bit   exp_sort [120];

    int exp_cyc[$];
    int exp_med[$];

    always #5 CLK = ~CLK;

    med_ctrl #(.NB(9)) u_dut9 (
        .CLK(CLK), .nRST(nRST), .DSI(DSI9), .DSI_MED(DSI_MED9),
        .BYP(BYP9), .DSO(DSO9), .BUSY(BUSY9)
`ifdef MED_CTRL_PROTO_CHECK_EN
        , .ERR(err9)
`endif
    );

    med_ctrl #(.NB(5)) u_dut5 (
        .CLK(CLK), .nRST(nRST), .DSI(DSI5), .DSI_MED(DSI_MED5),
        .BYP(BYP5), .DSO(DSO5), .BUSY(BUSY5)
`ifdef MED_CTRL_PROTO_CHECK_EN
        , .ERR(err5)
`endif
    );

    // Datapath: ring with a compare element between the last two taps.
    always @(posedge CLK) begin
        dp9[0] <= DSI_MED9 ? di9 : (BYP9 ? dp9[8] : ((dp9[7] < dp9[8]) ? dp9[7] : dp9[8]));
        for (int i = 1; i < 8; i++) dp9[i] <= dp9[i-1];
        dp9[8] <= BYP9 ? dp9[7] : ((dp9[7] > dp9[8]) ? dp9[7] : dp9[8]);
    end

    always @(posedge CLK) begin
        dp5[0] <= DSI_MED5 ? di5 : (BYP5 ? dp5[4] : ((dp5[3] < dp5[4]) ? dp5[3] : dp5[4]));
        for (int i = 1; i < 4; i++) dp5[i] <= dp5[i-1];
        dp5[4] <= BYP5 ? dp5[3] : ((dp5[3] > dp5[4]) ? dp5[3] : dp5[4]);
    end

    function automatic int med9(input int v[9]);
        int s[9];
        int t;
        s = v;
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
        return s[4];
    endfunction

    task automatic clr_sched();
        for (int k = 0; k < 120; k++) begin
            sch_dsi[k]  = 1'b0;
            sch_di[k]   = 0;
            exp_byp[k]  = 1'b1;
            exp_busy[k] = 1'b0;
            exp_sort[k] = 1'b0;
        end
        exp_cyc.delete();
        exp_med.delete();
    endtask

    // Schedules a full window starting at cycle s and records what it must produce.
    task automatic expect_win9(input int s, input int v[9]);
        int k;
        for (int i = 0; i < 9; i++) begin
            sch_dsi[s+i] = 1'b1;
            sch_di[s+i]  = v[i];
        end
        for (int i = s + 1; i < s + 49; i++) exp_busy[i] = 1'b1;
        k = s + 9;
        for (int p = 0; p < 4; p++) begin
            for (int z = 0; z < 8 - p; z++) begin exp_byp[k] = 1'b0; exp_sort[k] = 1'b1; k++; end
            for (int o = 0; o < p + 1; o++) begin exp_byp[k] = 1'b1; exp_sort[k] = 1'b1; k++; end
        end
        for (int z = 0; z < 4; z++) begin exp_byp[k] = 1'b0; exp_sort[k] = 1'b1; k++; end
        exp_cyc.push_back(s + 49);
        exp_med.push_back(med9(v));
    endtask

    // Entered and left 1 time unit after a rising edge.
    task automatic play9(input int n);
        for (int k = 0; k < n; k++) begin
            DSI9 = sch_dsi[k];
            di9  = sch_di[k];
            #1;
            obs_byp[k]  = BYP9;
            obs_dso[k]  = DSO9;
            obs_busy[k] = BUSY9;
            obs_dsim[k] = DSI_MED9;
            obs_do[k]   = dp9[8];
            @(posedge CLK); #1;
        end
        DSI9 = 1'b0;
    endtask

    task automatic pulse_reset();
        nRST = 1'b0;
        #1;
        @(posedge CLK); #1;
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        DSI9 = 1'b1;
        #1;
        n_tests++;
        if (DSI_MED9 !== 1'b1 || BUSY9 !== 1'b0 || DSO9 !== 1'b0 || BYP9 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: dsi_med=%b busy=%b dso=%b byp=%b, required 1 0 0 1",
                     DSI_MED9, BUSY9, DSO9, BYP9);
        end
        DSI9 = 1'b0;
        #1;
        n_tests++;
        if (DSI_MED9 !== 1'b0) begin
            n_fail++; $display("FAIL reset_dsi_med_follow: got %b, required 0", DSI_MED9);
        end
`ifdef MED_CTRL_PROTO_CHECK_EN
        n_tests++;
        if (err9 !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, required 0", err9); end
`endif
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(posedge CLK); #1;

        clr_sched();
        for (int i = 0; i < 9; i++) begin sch_dsi[i] = 1'b1; sch_di[i] = i; end
        play9(20);
        n_tests++;
        if (obs_busy[19] !== 1'b1 || obs_byp[19] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pre_sort: busy=%b byp=%b at cycle 19, required 1 0", obs_busy[19], obs_byp[19]);
        end
        nRST = 1'b0;
        #1;
        n_tests++;
        if (BUSY9 !== 1'b0 || DSO9 !== 1'b0 || BYP9 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_sort: busy=%b dso=%b byp=%b, required 0 0 1", BUSY9, DSO9, BYP9);
        end
        @(posedge CLK); #1;
        nRST = 1'b1;
        clr_sched();
        play9(60);
        for (int k = 0; k < 60; k++) begin
            n_tests++;
            if (obs_dso[k] !== 1'b0 || obs_busy[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_after: cycle %0d dso=%b busy=%b, required 0 0", k, obs_dso[k], obs_busy[k]);
            end
        end
    endtask

    task automatic test_nominal();
        int v[9] = '{9, 3, 7, 1, 5, 8, 2, 6, 4};
        int c, m;
        clr_sched();
        expect_win9(0, v);
        play9(60);
        for (int k = 0; k < 60; k++) begin
            n_tests++;
            if (obs_byp[k] !== exp_byp[k] || obs_busy[k] !== exp_busy[k] ||
                obs_dsim[k] !== (exp_sort[k] ? 1'b0 : sch_dsi[k])) begin
                n_fail++;
                $display("FAIL nominal_ctl: cycle %0d byp/busy/dsi_med=%b%b%b, required %b%b%b", k,
                         obs_byp[k], obs_busy[k], obs_dsim[k], exp_byp[k], exp_busy[k],
                         exp_sort[k] ? 1'b0 : sch_dsi[k]);
            end
            if (obs_dso[k] === 1'b1) begin
                n_tests++;
                if (exp_cyc.size() == 0) begin
                    n_fail++; $display("FAIL nominal_dso: unexpected pulse at cycle %0d", k);
                end else begin
                    c = exp_cyc.pop_front(); m = exp_med.pop_front();
                    if (k != c || obs_do[k] != m) begin
                        n_fail++;
                        $display("FAIL nominal_dso: cycle %0d DO=%0d, required cycle %0d DO=%0d", k, obs_do[k], c, m);
                    end
                end
            end
        end
        n_tests++;
        if (exp_cyc.size() != 0) begin
            n_fail++; $display("FAIL nominal_missing: %0d pulses not seen, required 0", exp_cyc.size());
        end
`ifdef MED_CTRL_PROTO_CHECK_EN
        n_tests++;
        if (err9 !== 1'b0) begin n_fail++; $display("FAIL nominal_err: got %b, required 0", err9); end
`endif
    endtask

    task automatic test_back_to_back();
        int a[9] = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
        int b[9] = '{30, 90, 10, 70, 50, 20, 80, 40, 60};
        int c, m;
        clr_sched();
        expect_win9(0, a);
        expect_win9(49, b);
        play9(110);
        for (int k = 0; k < 110; k++) begin
            n_tests++;
            if (obs_byp[k] !== exp_byp[k] || obs_busy[k] !== exp_busy[k]) begin
                n_fail++;
                $display("FAIL b2b_ctl: cycle %0d byp/busy=%b%b, required %b%b", k,
                         obs_byp[k], obs_busy[k], exp_byp[k], exp_busy[k]);
            end
            if (obs_dso[k] === 1'b1) begin
                n_tests++;
                if (exp_cyc.size() == 0) begin
                    n_fail++; $display("FAIL b2b_dso: unexpected pulse at cycle %0d", k);
                end else begin
                    c = exp_cyc.pop_front(); m = exp_med.pop_front();
                    if (k != c || obs_do[k] != m) begin
                        n_fail++;
                        $display("FAIL b2b_dso: cycle %0d DO=%0d, required cycle %0d DO=%0d", k, obs_do[k], c, m);
                    end
                end
            end
        end
        n_tests++;
        if (exp_cyc.size() != 0) begin
            n_fail++; $display("FAIL b2b_missing: %0d pulses not seen, required 0", exp_cyc.size());
        end
    endtask

    task automatic test_short_burst();
        clr_sched();
        for (int i = 0; i < 4; i++) begin sch_dsi[i] = 1'b1; sch_di[i] = 100 + i; end
        play9(100);
        n_tests++;
        if (obs_busy[3] !== 1'b1 || obs_busy[5] !== 1'b0 || obs_byp[5] !== 1'b1) begin
            n_fail++;
            $display("FAIL short_state: busy@3=%b busy@5=%b byp@5=%b, required 1 0 1",
                     obs_busy[3], obs_busy[5], obs_byp[5]);
        end
        for (int k = 0; k < 100; k++) begin
            n_tests++;
            if (obs_dso[k] !== 1'b0) begin
                n_fail++; $display("FAIL short_dso: pulse at cycle %0d, required none", k);
            end
        end
`ifdef MED_CTRL_PROTO_CHECK_EN
        n_tests++;
        if (err9 !== 1'b1) begin n_fail++; $display("FAIL short_err: got %b, required 1", err9); end
`endif
    endtask

    task automatic test_sort_glitch();
        int v[9] = '{9, 3, 7, 1, 5, 8, 2, 6, 4};
        int c, m;
        pulse_reset();
`ifdef MED_CTRL_PROTO_CHECK_EN
        n_tests++;
        if (err9 !== 1'b0) begin n_fail++; $display("FAIL glitch_err_clear: got %b, required 0", err9); end
`endif
        clr_sched();
        expect_win9(0, v);
        sch_dsi[15] = 1'b1;
        sch_di[15]  = 999;
        play9(60);
        for (int k = 0; k < 60; k++) begin
            n_tests++;
            if (obs_byp[k] !== exp_byp[k] || obs_dsim[k] !== (exp_sort[k] ? 1'b0 : sch_dsi[k])) begin
                n_fail++;
                $display("FAIL glitch_ctl: cycle %0d byp/dsi_med=%b%b, required %b%b", k,
                         obs_byp[k], obs_dsim[k], exp_byp[k], exp_sort[k] ? 1'b0 : sch_dsi[k]);
            end
            if (obs_dso[k] === 1'b1) begin
                n_tests++;
                if (exp_cyc.size() == 0) begin
                    n_fail++; $display("FAIL glitch_dso: unexpected pulse at cycle %0d", k);
                end else begin
                    c = exp_cyc.pop_front(); m = exp_med.pop_front();
                    if (k != c || obs_do[k] != m) begin
                        n_fail++;
                        $display("FAIL glitch_dso: cycle %0d DO=%0d, required cycle %0d DO=%0d", k, obs_do[k], c, m);
                    end
                end
            end
        end
        n_tests++;
        if (exp_cyc.size() != 0) begin
            n_fail++; $display("FAIL glitch_missing: %0d pulses not seen, required 0", exp_cyc.size());
        end
`ifdef MED_CTRL_PROTO_CHECK_EN
        n_tests++;
        if (err9 !== 1'b1) begin n_fail++; $display("FAIL glitch_err: got %b, required 1", err9); end
`endif
    endtask

    task automatic test_nb5();
        int   v[5] = '{4, 1, 5, 2, 3};
        logic eb[25];
        int   k;
        int   n_dso = 0;
        for (int i = 0; i < 25; i++) eb[i] = 1'b1;
        k = 5;
        for (int p = 0; p < 2; p++) begin
            for (int z = 0; z < 4 - p; z++) begin eb[k] = 1'b0; k++; end
            k = k + p + 1;
        end
        eb[k] = 1'b0; eb[k+1] = 1'b0;
        for (int t = 0; t < 25; t++) begin
            DSI5 = (t < 5);
            di5  = (t < 5) ? v[t] : 0;
            #1;
            n_tests++;
            if (BYP5 !== eb[t] || BUSY5 !== ((t >= 1 && t < 17) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL nb5_ctl: cycle %0d byp=%b busy=%b, required byp=%b", t, BYP5, BUSY5, eb[t]);
            end
            if (DSO5 === 1'b1) begin
                n_dso++;
                n_tests++;
                if (t != 17 || dp5[4] != 3) begin
                    n_fail++;
                    $display("FAIL nb5_dso: cycle %0d DO=%0d, required cycle 17 DO=3", t, dp5[4]);
                end
            end
            @(posedge CLK); #1;
        end
        DSI5 = 1'b0;
        n_tests++;
        if (n_dso != 1) begin n_fail++; $display("FAIL nb5_count: %0d pulses, required 1", n_dso); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST = 1'b0;
        DSI9 = 1'b0;
        DSI5 = 1'b0;
        di9  = 0;
        di5  = 0;
        repeat (3) @(posedge CLK);
        #1;
        test_reset();
        test_nominal();
        test_back_to_back();
        test_short_burst();
        test_sort_glitch();
        test_nb5();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
